ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit at the front of the NPC core pipeline, upstream of the IF/ID pipeline register. It owns the program counter and issues one word read per instruction to the instruction-memory port. It then presents the returned `{pc, inst}` pair on a valid/ready producer interface that the IF/ID register consumes. A redirect input from the execute stage restarts fetch at a new address and kills any in-flight fetch.

## Interface
- `RESET_ADDR`, default `32'h8000_0000`: PC value after reset (matches `CPU_RESET_ADDR`).
- `clk` input 1: single clock, all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `imem_req_valid` output 1: read request valid.
- `imem_req_ready` input 1: memory accepts the request this cycle.
- `imem_req_addr` output 32: word address, bits [1:0] always 0.
- `imem_resp_valid` input 1: read data valid.
- `imem_resp_ready` output 1: IFU accepts read data.
- `imem_resp_data` input 32: instruction word.
- `redirect_valid` input 1: restart fetch (branch/jump taken).
- `redirect_pc` input 32: new fetch address; bits [1:0] ignored and treated as 0.
- `o_valid` output 1: `fetch_pc`/`fetch_inst` valid toward IF/ID.
- `o_ready` input 1: IF/ID accepts.
- `fetch_pc` output 32: PC of the offered instruction.
- `fetch_inst` output 32: offered instruction.
- `perf_fetch_cnt` output 32: retired-fetch count. Present only with `IFU_PERF_EN`.

## Operation
- State registers: `state` ∈ {REQ, WAIT, HOLD}, `pc` (32), `inst_q` (32), `kill` (1).
- Reset (`rst`=1 at posedge):
  - state←REQ, pc←RESET_ADDR, inst_q←`INST_NOP`, kill←0.
  - While `rst` is high, `imem_req_valid`, `imem_resp_ready` and `o_valid` are forced to 0.
  - Reset mid-transaction abandons any in-flight request. The memory must also be reset.
- REQ:
  - `imem_req_valid`=1, `imem_req_addr`=pc.
  - On `imem_req_ready`: go to WAIT.
  - The address may change while the request is pending; the memory is SRAM-style and samples only on handshake.
- WAIT:
  - `imem_resp_ready`=1.
  - On `imem_resp_valid` with kill=0: inst_q←`imem_resp_data`, go to HOLD.
  - On `imem_resp_valid` with kill=1: discard the data, kill←0, go to REQ.
- HOLD:
  - `o_valid`=~`redirect_valid`, `fetch_pc`=pc, `fetch_inst`=inst_q.
  - On `o_valid & o_ready`: pc←pc+4 (modulo 2^32, so `FFFF_FFFC`→`0000_0000`), go to REQ.
  - Outputs stay stable until the handshake completes.
- Redirect has priority over every other event in the same cycle. pc←{redirect_pc[31:2],2'b00}, plus the following per state:
  - REQ, no request handshake this cycle: stay in REQ. The next request uses the new pc.
  - REQ, request handshake this cycle: the old-pc request is issued. Go to WAIT with kill←1.
  - WAIT, no response this cycle: kill←1, stay in WAIT.
  - WAIT, response this cycle: discard it, kill←0, go to REQ.
  - HOLD: `o_valid` is 0 this cycle, so no handshake occurs. Drop inst_q and go to REQ.
- At most one outstanding memory request. kill is never set outside WAIT.
- Output values when not valid:
  - `fetch_pc`/`fetch_inst` reflect pc/inst_q; consumers must ignore them while `o_valid` is 0.
  - `imem_req_addr`=pc in all states.

## Timing
- Zero-wait memory gives a minimum of 3 cycles per instruction: REQ→WAIT→HOLD, then back to REQ on `o_ready`.
- The first request is visible in the first cycle after `rst` deasserts, with addr=RESET_ADDR.
- Response-to-`o_valid` latency: 1 cycle (data is registered in inst_q).
- `o_valid` has a combinational path from `redirect_valid`. `o_valid`, `imem_req_valid` and `imem_resp_ready` are otherwise decoded from `state` only.
- Backpressure from `o_ready`=0 holds HOLD indefinitely. No new request is issued during that time.

## Configuration
- `IFU_PERF_EN` defined:
  - Adds port `perf_fetch_cnt` and a 32-bit counter.
  - Counter resets to 0 and increments by 1 on every `o_valid & o_ready` handshake.
  - Wraps `FFFF_FFFF`→`0`. Killed fetches are not counted.
- `IFU_PERF_EN` undefined: no port, no counter. Behaviour is otherwise identical.

## Test plan
- Reset then zero-wait memory returning `inst = addr ^ 32'hA5A5_0000`, `o_ready`=1 → offered pcs are `8000_0000`, `8000_0004`, `8000_0008`, with each `fetch_inst` matching. Handshakes occur every 3 cycles.
- `o_ready`=0 for 10 cycles in HOLD → `o_valid`, `fetch_pc` and `fetch_inst` stay constant. `imem_req_valid`=0 throughout.
- Redirect to `8000_0103` during WAIT, response arrives 2 cycles later → the response is discarded and the next request address is `8000_0100`. No `o_valid` occurs for the killed fetch.
- Redirect in the same cycle as `imem_resp_valid` → data is discarded and state goes to REQ with addr=`8000_0200`. In the HOLD-state variant, `o_valid`=0 in the redirect cycle even with `o_ready`=1.
- `RESET_ADDR`=`FFFF_FFFC`, two fetches → second `fetch_pc`=`0000_0000`. Then assert `rst` while in WAIT → the next request is at `FFFF_FFFC` and kill=0.
- With `IFU_PERF_EN`: 5 accepted fetches plus 1 killed fetch → `perf_fetch_cnt`=5. After `rst` it reads 0.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem read per instruction and offers {pc, inst}
// to IF/ID. Optional retired-fetch counter is enabled by defining IFU_PERF_EN.
module ifu_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    output logic        imem_resp_ready,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        o_valid,
    input  logic        o_ready,
`ifdef IFU_PERF_EN
    output logic [31:0] perf_fetch_cnt,
`endif
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_inst
);

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        kill_q;

    assign imem_req_valid  = !rst && (state_q == StReq);
    assign imem_resp_ready = !rst && (state_q == StWait);
    assign o_valid         = !rst && (state_q == StHold) && !redirect_valid;
    assign imem_req_addr   = pc_q;
    assign fetch_pc        = pc_q;
    assign fetch_inst      = inst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StReq;
            pc_q    <= RESET_ADDR & WORD_MASK;
            inst_q  <= INST_NOP;
            kill_q  <= 1'b0;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc & WORD_MASK;
            unique case (state_q)
                StReq: begin
                    // Old-pc request still goes out; its response must be dropped.
                    if (imem_req_ready) begin
                        state_q <= StWait;
                        kill_q  <= 1'b1;
                    end
                end
                StWait: begin
                    if (imem_resp_valid) begin
                        state_q <= StReq;
                        kill_q  <= 1'b0;
                    end else begin
                        kill_q <= 1'b1;
                    end
                end
                StHold:  state_q <= StReq;
                default: state_q <= StReq;
            endcase
        end else begin
            unique case (state_q)
                StReq: begin
                    if (imem_req_ready) state_q <= StWait;
                end
                StWait: begin
                    if (imem_resp_valid) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= StReq;
                        end else begin
                            inst_q  <= imem_resp_data;
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (o_ready) begin
                        pc_q    <= pc_q + 32'd4;
                        state_q <= StReq;
                    end
                end
                default: state_q <= StReq;
            endcase
        end
    end

`ifdef IFU_PERF_EN
    logic [31:0] perf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_q <= 32'd0;
        end else if (o_valid && o_ready) begin
            perf_cnt_q <= perf_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch: a latency-programmable memory model feeds the main
// instance; a second instance with RESET_ADDR=FFFF_FFFC is driven by hand for the wrap cases.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance
    logic        rst = 1'b1;
    logic        req_valid, req_ready, resp_valid, resp_ready;
    logic [31:0] req_addr, resp_data, redirect_pc, fetch_pc, fetch_inst, perf;
    logic        redirect_valid, o_valid, o_ready;

    ifu_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (req_valid),
        .imem_req_ready  (req_ready),
        .imem_req_addr   (req_addr),
        .imem_resp_valid (resp_valid),
        .imem_resp_ready (resp_ready),
        .imem_resp_data  (resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .o_valid         (o_valid),
        .o_ready         (o_ready),
`ifdef IFU_PERF_EN
        .perf_fetch_cnt  (perf),
`endif
        .fetch_pc        (fetch_pc),
        .fetch_inst      (fetch_inst)
    );

    // Memory model: responds mem_lat cycles after entering WAIT; data = addr ^ A5A5_0000.
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          mem_lat = 0;

    assign resp_valid = mem_pend && (mem_cnt == 0);
    assign resp_data  = mem_addr ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        if (rst) begin
            mem_pend <= 1'b0;
            mem_cnt  <= 0;
        end else if (req_valid && req_ready) begin
            mem_pend <= 1'b1;
            mem_addr <= req_addr;
            mem_cnt  <= mem_lat;
        end else if (mem_pend && mem_cnt != 0) begin
            mem_cnt <= mem_cnt - 1;
        end else if (resp_valid && resp_ready) begin
            mem_pend <= 1'b0;
        end
    end

    // Wrap-around instance
    logic        rst2 = 1'b1;
    logic        req_valid2, req_ready2, resp_valid2, resp_ready2;
    logic [31:0] req_addr2, resp_data2, redirect_pc2, fetch_pc2, fetch_inst2, perf2;
    logic        redirect_valid2, o_valid2, o_ready2;

    ifu_fetch #(.RESET_ADDR(32'hFFFF_FFFC)) dut2 (
        .clk             (clk),
        .rst             (rst2),
        .imem_req_valid  (req_valid2),
        .imem_req_ready  (req_ready2),
        .imem_req_addr   (req_addr2),
        .imem_resp_valid (resp_valid2),
        .imem_resp_ready (resp_ready2),
        .imem_resp_data  (resp_data2),
        .redirect_valid  (redirect_valid2),
        .redirect_pc     (redirect_pc2),
        .o_valid         (o_valid2),
        .o_ready         (o_ready2),
`ifdef IFU_PERF_EN
        .perf_fetch_cnt  (perf2),
`endif
        .fetch_pc        (fetch_pc2),
        .fetch_inst      (fetch_inst2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        o_ready = 1'b1; req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        step(); step();
        checks++;
        if ({req_valid, resp_ready, o_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000", {req_valid, resp_ready, o_valid});
        end
        checks++;
        if ({fetch_pc, fetch_inst} !== {32'h8000_0000, 32'h0000_0013}) begin
            errors++;
            $display("FAIL reset_state: got pc=%h inst=%h want 80000000/00000013",
                     fetch_pc, fetch_inst);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({req_valid, req_addr} !== {1'b1, 32'h8000_0000}) begin
            errors++;
            $display("FAIL first_req: got v=%b addr=%h want 1/80000000", req_valid, req_addr);
        end
    endtask

    task automatic test_stream;
        logic [31:0] exp_pc [3];
        logic [31:0] exp_inst [3];
        exp_pc   = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
        exp_inst = '{32'h25A5_0000, 32'h25A5_0004, 32'h25A5_0008};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({req_valid, o_valid, req_addr} !== {2'b10, exp_pc[i]}) begin
                errors++;
                $display("FAIL stream_req%0d: got rv=%b ov=%b addr=%h want 1/0/%h",
                         i, req_valid, o_valid, req_addr, exp_pc[i]);
            end
            step();
            checks++;
            if ({req_valid, resp_ready, o_valid} !== 3'b010) begin
                errors++;
                $display("FAIL stream_wait%0d: got %b want 010", i,
                         {req_valid, resp_ready, o_valid});
            end
            step();
            checks++;
            if ({o_valid, req_valid, fetch_pc, fetch_inst} !== {2'b10, exp_pc[i], exp_inst[i]}) begin
                errors++;
                $display("FAIL stream_hold%0d: got ov=%b rv=%b pc=%h inst=%h want 1/0/%h/%h", i,
                         o_valid, req_valid, fetch_pc, fetch_inst, exp_pc[i], exp_inst[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure;
        o_ready = 1'b0;
        step(); step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({o_valid, req_valid, fetch_pc, fetch_inst} !==
                {2'b10, 32'h8000_000C, 32'h25A5_000C}) begin
                errors++;
                $display("FAIL bp_hold%0d: got ov=%b rv=%b pc=%h inst=%h want 1/0/8000000c/25a5000c",
                         i, o_valid, req_valid, fetch_pc, fetch_inst);
            end
            step();
        end
        o_ready = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got ov=%b want 1", o_valid);
        end
        step();
        checks++;
        if ({req_valid, req_addr} !== {1'b1, 32'h8000_0010}) begin
            errors++;
            $display("FAIL bp_next_req: got v=%b addr=%h want 1/80000010", req_valid, req_addr);
        end
    endtask

    task automatic test_redirect_wait;
        mem_lat = 2;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
        #1;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_redirect_cycle: got ov=%b want 0", o_valid);
        end
        step();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({req_valid, resp_ready, o_valid, resp_valid} !== 4'b0100) begin
            errors++;
            $display("FAIL rw_still_wait: got %b want 0100",
                     {req_valid, resp_ready, o_valid, resp_valid});
        end
        step();
        checks++;
        if ({resp_valid, o_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rw_resp_arrives: got rsp=%b ov=%b want 1/0", resp_valid, o_valid);
        end
        mem_lat = 0;
        step();
        checks++;
        if ({req_valid, o_valid, req_addr} !== {2'b10, 32'h8000_0100}) begin
            errors++;
            $display("FAIL rw_next_req: got rv=%b ov=%b addr=%h want 1/0/80000100",
                     req_valid, o_valid, req_addr);
        end
    endtask

    task automatic test_redirect_resp;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        step();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({req_valid, resp_ready, o_valid, req_addr} !== {3'b100, 32'h8000_0200}) begin
            errors++;
            $display("FAIL rr_next_req: got %b addr=%h want 100/80000200",
                     {req_valid, resp_ready, o_valid}, req_addr);
        end
        step(); step();
        checks++;
        if ({o_valid, fetch_pc, fetch_inst} !== {1'b1, 32'h8000_0200, 32'h25A5_0200}) begin
            errors++;
            $display("FAIL rr_refetch: got ov=%b pc=%h inst=%h want 1/80000200/25a50200",
                     o_valid, fetch_pc, fetch_inst);
        end
        step();
    endtask

    task automatic test_redirect_hold;
        step(); step();
        checks++;
        if ({o_valid, fetch_pc} !== {1'b1, 32'h8000_0204}) begin
            errors++;
            $display("FAIL rh_hold: got ov=%b pc=%h want 1/80000204", o_valid, fetch_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        #1;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rh_ovalid_masked: got ov=%b want 0", o_valid);
        end
        step();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({req_valid, o_valid, req_addr} !== {2'b10, 32'h8000_0300}) begin
            errors++;
            $display("FAIL rh_next_req: got rv=%b ov=%b addr=%h want 1/0/80000300",
                     req_valid, o_valid, req_addr);
        end
    endtask

    task automatic test_redirect_req;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0401;
        step();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({resp_ready, resp_valid, o_valid, resp_data} !== {3'b110, 32'h25A5_0300}) begin
            errors++;
            $display("FAIL rq_old_req_issued: got %b data=%h want 110/25a50300",
                     {resp_ready, resp_valid, o_valid}, resp_data);
        end
        step();
        checks++;
        if ({req_valid, o_valid, req_addr} !== {2'b10, 32'h8000_0400}) begin
            errors++;
            $display("FAIL rq_next_req: got rv=%b ov=%b addr=%h want 1/0/80000400",
                     req_valid, o_valid, req_addr);
        end
    endtask

    task automatic test_perf;
`ifdef IFU_PERF_EN
        checks++;
        if (perf !== 32'd5) begin
            errors++;
            $display("FAIL perf_count: got %0d want 5", perf);
        end
`endif
        rst = 1'b1;
        step();
        checks++;
        if ({req_valid, resp_ready, o_valid, req_addr} !== {3'b000, 32'h8000_0000}) begin
            errors++;
            $display("FAIL rerst_state: got %b addr=%h want 000/80000000",
                     {req_valid, resp_ready, o_valid}, req_addr);
        end
`ifdef IFU_PERF_EN
        checks++;
        if (perf !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: got %0d want 0", perf);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_wrap;
        rst2 = 1'b0;
        #1;
        checks++;
        if ({req_valid2, req_addr2} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_first_req: got v=%b addr=%h want 1/fffffffc", req_valid2, req_addr2);
        end
        step();
        resp_valid2 = 1'b1; resp_data2 = 32'h1111_1111;
        step();
        resp_valid2 = 1'b0;
        #1;
        checks++;
        if ({o_valid2, fetch_pc2, fetch_inst2} !== {1'b1, 32'hFFFF_FFFC, 32'h1111_1111}) begin
            errors++;
            $display("FAIL wrap_fetch0: got ov=%b pc=%h inst=%h want 1/fffffffc/11111111",
                     o_valid2, fetch_pc2, fetch_inst2);
        end
        step();
        step();
        resp_valid2 = 1'b1; resp_data2 = 32'h2222_2222;
        step();
        resp_valid2 = 1'b0;
        #1;
        checks++;
        if ({o_valid2, fetch_pc2, fetch_inst2} !== {1'b1, 32'h0000_0000, 32'h2222_2222}) begin
            errors++;
            $display("FAIL wrap_fetch1: got ov=%b pc=%h inst=%h want 1/00000000/22222222",
                     o_valid2, fetch_pc2, fetch_inst2);
        end
        step();
        step();
        checks++;
        if ({req_valid2, resp_ready2} !== 2'b01) begin
            errors++;
            $display("FAIL wrap_in_wait: got %b want 01", {req_valid2, resp_ready2});
        end
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        #1;
        checks++;
        if ({req_valid2, req_addr2} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_rst_req: got v=%b addr=%h want 1/fffffffc", req_valid2, req_addr2);
        end
        step();
        resp_valid2 = 1'b1; resp_data2 = 32'h3333_3333;
        step();
        resp_valid2 = 1'b0;
        #1;
        checks++;
        if ({o_valid2, fetch_inst2} !== {1'b1, 32'h3333_3333}) begin
            errors++;
            $display("FAIL wrap_no_kill: got ov=%b inst=%h want 1/33333333", o_valid2, fetch_inst2);
        end
    endtask

    initial begin
        req_ready2 = 1'b1; resp_valid2 = 1'b0; resp_data2 = '0;
        redirect_valid2 = 1'b0; redirect_pc2 = '0; o_ready2 = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_resp();
        test_redirect_hold();
        test_redirect_req();
        test_perf();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
